pipe_skid_stage: RTL and testbench

//  Parametrised elastic pipeline register for the inter-stage buses (IF/ID and later ID/EX etc.).
//  - Replaces the fixed-width flush/stall latch with a valid/ready stage and a 2-entry skid buffer.
//  - Cache-miss back-pressure therefore never drops or duplicates an instruction.
//  - Keeps the hazard-unit flush/stall controls.
//  - Counts entries killed by flushes, for branch-predictor statistics.

---
 rtl/pipe_skid_stage_pkg.sv | 19 +
 rtl/pipe_entry_reg.sv | 44 ++++
 rtl/pipe_skid_stage.sv | 136 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for elastic inter-stage pipeline registers.
// State encodings double as the occupancy count.
package pipe_skid_stage_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // IF/ID payload layout: {instr, pc_plus4, pred_taken}
   localparam int IFID_PRED_LSB  = 0;
   localparam int IFID_PC_LSB    = 1;
   localparam int IFID_INSTR_LSB = 33;
   localparam int IFID_W         = 65;

endpackage

// File: rtl/pipe_entry_reg.sv
// One valid+payload slot of the skid stage.
// Clear wins over load and parks the payload at BUBBLE.
module pipe_entry_reg #(
   parameter int                 DATA_W = 65,
   parameter logic [DATA_W-1:0] BUBBLE = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d,
   output logic              valid,
   output logic [DATA_W-1:0] data
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clear) begin
         valid_d = 1'b0;
         data_d  = BUBBLE;
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= BUBBLE;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline stage with a 2-entry skid buffer,
// hazard flush/stall controls and a saturating flush-drop counter.
module pipe_skid_stage
   import pipe_skid_stage_pkg::*;
#(
   parameter int                 DATA_W = IFID_W,
   parameter logic [DATA_W-1:0] BUBBLE = '0,
   parameter int                 CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              stall,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  flush_drop_cnt
);

   state_e            state_q, state_d;
   logic              main_v, skid_v;
   logic [DATA_W-1:0] main_dat, skid_dat, main_nxt;
   logic              acc, emt;
   logic              main_ld, main_clr, skid_ld, skid_clr;
   logic              main_from_skid;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W:0]    cnt_sum;
   logic [1:0]        drop;

   // Ready never looks at out_ready, keeping the upstream path short.
   assign in_ready  = !skid_v && !flush && !stall;
   assign out_valid = main_v && !flush && !stall;
   assign out_data  = main_dat;
   assign acc       = in_valid && in_ready;
   assign emt       = out_valid && out_ready;
   assign occupancy = state_q;
   assign flush_drop_cnt = cnt_q;
   assign main_nxt  = main_from_skid ? skid_dat : in_data;

   always_comb begin
      state_d        = state_q;
      main_ld        = 1'b0;
      main_clr       = 1'b0;
      skid_ld        = 1'b0;
      skid_clr       = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         state_d  = ST_EMPTY;
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else if (!stall) begin
         unique case (state_q)
            ST_EMPTY: begin
               if (acc) begin
                  state_d = ST_ONE;
                  main_ld = 1'b1;
               end
            end
            ST_ONE: begin
               if (acc && emt) begin
                  main_ld = 1'b1;
               end else if (acc) begin
                  state_d = ST_FULL;
                  skid_ld = 1'b1;
               end else if (emt) begin
                  state_d  = ST_EMPTY;
                  main_clr = 1'b1;
               end
            end
            ST_FULL: begin
               if (emt) begin
                  state_d        = ST_ONE;
                  main_ld        = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clr       = 1'b1;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      drop    = {1'b0, main_v} + {1'b0, skid_v};
      cnt_sum = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, drop};
      cnt_d   = cnt_q;
      if (flush) begin
         cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   pipe_entry_reg #(
      .DATA_W (DATA_W),
      .BUBBLE (BUBBLE)
   ) u_main (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (main_ld),
      .clear (main_clr),
      .d     (main_nxt),
      .valid (main_v),
      .data  (main_dat)
   );

   pipe_entry_reg #(
      .DATA_W (DATA_W),
      .BUBBLE (BUBBLE)
   ) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (skid_ld),
      .clear (skid_clr),
      .d     (in_data),
      .valid (skid_v),
      .data  (skid_dat)
   );

   a_skid_implies_main: assert property (
      @(posedge clk) disable iff (!rst_n) !(skid_v && !main_v)
   );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomised bench for pipe_skid_stage against a FIFO-queue model.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_pipe_skid_stage;

   localparam int DW = 65;
   localparam logic [DW-1:0] BUB = {32'h0000_0013, 32'h0, 1'b0};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          stall = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] in_data = '0;

   logic          in_ready, out_valid;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;
   logic [15:0]   cnt16;
   logic          s_in_ready, s_out_valid;
   logic [DW-1:0] s_out_data;
   logic [1:0]    s_occ;
   logic [1:0]    cnt2;

   always #5 clk = ~clk;

   pipe_skid_stage #(
      .DATA_W (DW),
      .BUBBLE (BUB),
      .CNT_W  (16)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .stall          (stall),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .occupancy      (occupancy),
      .flush_drop_cnt (cnt16)
   );

   pipe_skid_stage #(
      .DATA_W (DW),
      .BUBBLE (BUB),
      .CNT_W  (2)
   ) dut_s (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .stall          (stall),
      .in_valid       (in_valid),
      .in_ready       (s_in_ready),
      .in_data        (in_data),
      .out_valid      (s_out_valid),
      .out_ready      (out_ready),
      .out_data       (s_out_data),
      .occupancy      (s_occ),
      .flush_drop_cnt (cnt2)
   );

   int n_checks = 0;
   int n_fail = 0;

   logic [DW-1:0] mq[$];
   int            m_cnt16 = 0;
   int            m_cnt2 = 0;
   bit            m_acc;

   logic [155:0] obs;
   assign obs = {out_valid, in_ready, occupancy, out_data, cnt16,
                 s_out_valid, s_in_ready, s_occ, s_out_data, cnt2};

   function automatic logic [155:0] exp_vec();
      logic          v, r;
      logic [1:0]    o;
      logic [DW-1:0] d;
      v = (mq.size() > 0) && !flush && !stall;
      r = (mq.size() < 2) && !flush && !stall;
      o = 2'(mq.size());
      d = (mq.size() > 0) ? mq[0] : BUB;
      return {v, r, o, d, 16'(m_cnt16), v, r, o, d, 2'(m_cnt2)};
   endfunction

   function automatic logic [DW-1:0] rnd_pay();
      return {$urandom(), $urandom(), 1'($urandom())};
   endfunction

   task automatic drive(bit fl, bit st, bit iv,
                        logic [DW-1:0] d, bit ordy);
      @(negedge clk);
      flush = fl;
      stall = st;
      in_valid = iv;
      in_data = d;
      out_ready = ordy;
      #1;
   endtask

   // Advance the queue model across one rising edge.
   task automatic tick();
      bit do_acc, do_emt;
      int drop;
      @(posedge clk);
      m_acc = 1'b0;
      if (!rst_n) return;
      do_emt = mq.size() > 0 && !flush && !stall && out_ready;
      do_acc = in_valid && mq.size() < 2 && !flush && !stall;
      if (flush) begin
         drop = mq.size();
         m_cnt16 = (m_cnt16 + drop > 65535) ? 65535 : m_cnt16 + drop;
         m_cnt2 = (m_cnt2 + drop > 3) ? 3 : m_cnt2 + drop;
         mq.delete();
      end else begin
         if (do_emt) void'(mq.pop_front());
         if (do_acc) mq.push_back(in_data);
         m_acc = do_acc;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_hold: obs=%h exp=%h", obs, exp_vec());
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         drive(0, 0, 0, '0, 0);
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle: obs=%h exp=%h", obs, exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_stream();
      logic [DW-1:0] a[5];
      int k = 0;
      foreach (a[i]) a[i] = rnd_pay();
      repeat (8) begin
         drive(0, 0, k < 5, (k < 5) ? a[k] : '0, 1);
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL stream k=%0d: obs=%h exp=%h",
                     k, obs, exp_vec());
         end
         tick();
         if (m_acc) k++;
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] a[3];
      bit ordy[9] = '{1, 0, 0, 1, 1, 1, 1, 1, 1};
      int k = 0;
      foreach (a[i]) a[i] = rnd_pay();
      foreach (ordy[c]) begin
         drive(0, 0, k < 3, (k < 3) ? a[k] : '0, ordy[c]);
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL backpressure c=%0d: obs=%h exp=%h",
                     c, obs, exp_vec());
         end
         tick();
         if (m_acc) k++;
      end
   endtask

   task automatic test_flush();
      drive(0, 0, 1, rnd_pay(), 0);
      tick();
      drive(0, 0, 1, rnd_pay(), 0);
      tick();
      drive(1, 0, 1, rnd_pay(), 0);
      n_checks++;
      if (obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL flush_full: obs=%h exp=%h", obs, exp_vec());
      end
      tick();
      drive(0, 0, 0, '0, 0);
      n_checks++;
      if (obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL flush_after: obs=%h exp=%h", obs, exp_vec());
      end
      tick();
      drive(1, 0, 0, '0, 1);
      tick();
      drive(0, 0, 0, '0, 1);
      n_checks++;
      if (obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL flush_empty: obs=%h exp=%h", obs, exp_vec());
      end
      tick();
   endtask

   task automatic test_stall();
      logic [DW-1:0] nxt;
      nxt = rnd_pay();
      drive(0, 0, 1, rnd_pay(), 0);
      tick();
      repeat (3) begin
         drive(0, 1, 1, nxt, 1);
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL stall: obs=%h exp=%h", obs, exp_vec());
         end
         tick();
      end
      drive(0, 0, 0, '0, 1);
      n_checks++;
      if (obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL stall_release: obs=%h exp=%h", obs, exp_vec());
      end
      tick();
      drive(0, 0, 1, rnd_pay(), 0);
      tick();
      drive(1, 1, 1, rnd_pay(), 1);
      n_checks++;
      if (obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL flush_stall: obs=%h exp=%h", obs, exp_vec());
      end
      tick();
      drive(0, 0, 0, '0, 1);
      n_checks++;
      if (obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL flush_stall_after: obs=%h exp=%h", obs, exp_vec());
      end
      tick();
   endtask

   task automatic test_async_reset();
      drive(0, 0, 1, rnd_pay(), 0);
      tick();
      drive(0, 0, 1, rnd_pay(), 0);
      n_checks++;
      if (obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL areset_full: obs=%h exp=%h", obs, exp_vec());
      end
      tick();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      mq.delete();
      m_cnt16 = 0;
      m_cnt2 = 0;
      #1;
      n_checks++;
      if (obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL areset_now: obs=%h exp=%h", obs, exp_vec());
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, '0, 1);
      n_checks++;
      if (obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL areset_release: obs=%h exp=%h", obs, exp_vec());
      end
      tick();
   endtask

   task automatic test_saturation();
      repeat (4) begin
         drive(0, 0, 1, rnd_pay(), 0);
         tick();
         drive(0, 0, 1, rnd_pay(), 0);
         tick();
         drive(1, 0, 0, '0, 0);
         tick();
         drive(0, 0, 0, '0, 0);
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL saturate: obs=%h exp=%h", obs, exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] pend;
      bit            fl, st, iv, ordy;
      pend = rnd_pay();
      repeat (500) begin
         fl = ($urandom_range(0, 19) == 0);
         st = ($urandom_range(0, 9) == 0);
         iv = 1'($urandom());
         ordy = ($urandom_range(0, 3) != 0);
         drive(fl, st, iv, pend, ordy);
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL random: obs=%h exp=%h", obs, exp_vec());
         end
         tick();
         if (m_acc) pend = rnd_pay();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_stream();
      test_back_to_back();
      test_flush();
      test_stall();
      test_async_reset();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
